// File: rtl/monitoramento_pressao.sv
// Pressure-sensor supervisor: classifies valid samples against low/high limits with
// hysteresis and N-sample confirmation, tracks alarm entries and min/max statistics.
module monitoramento_pressao #(
   parameter int unsigned N            = 8,
   parameter int unsigned LIMITE_BAIXO = 50,
   parameter int unsigned LIMITE_ALTO  = 150,
   parameter int unsigned HIST         = 0,
   parameter int unsigned CONFIRMA     = 1,
   parameter int unsigned CW           = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          amostra_valida,
   input  logic [N-1:0]  pressao,
   input  logic          limpa,
   output logic [1:0]    alerta,
   output logic          alerta_mudou,
   output logic [CW-1:0] cont_baixo,
   output logic [CW-1:0] cont_alto,
   output logic [N-1:0]  pressao_min,
   output logic [N-1:0]  pressao_max
);

   localparam bit CFG_FALHA = (LIMITE_BAIXO >= LIMITE_ALTO) ||
                              (HIST >= LIMITE_ALTO - LIMITE_BAIXO);
   localparam int unsigned CNTW = (CONFIRMA > 1) ? $clog2(CONFIRMA + 1) : 1;

   // Thresholds widened by one bit so LIMITE_BAIXO+HIST cannot wrap
   localparam logic [N:0] LB  = (N+1)'(LIMITE_BAIXO);
   localparam logic [N:0] LA  = (N+1)'(LIMITE_ALTO);
   localparam logic [N:0] LBH = (N+1)'(LIMITE_BAIXO + HIST);
   localparam logic [N:0] LAH = (N+1)'(LIMITE_ALTO - HIST);

   typedef enum logic [1:0] {
      S_NORMAL = 2'b00,
      S_BAIXO  = 2'b01,
      S_ALTO   = 2'b10,
      S_FALHA  = 2'b11
   } estado_t;

   estado_t         estado_q;
   estado_t         candidato_q;
   estado_t         classe_d;
   logic            mudou_q;
   logic [CNTW-1:0] conta_q;
   logic [CNTW-1:0] conta_d;
   logic            confirma_d;
   logic [CW-1:0]   cont_baixo_q;
   logic [CW-1:0]   cont_alto_q;
   logic [N-1:0]    min_q;
   logic [N-1:0]    max_q;
   logic [N:0]      amostra;

   always_comb begin
      amostra  = {1'b0, pressao};
      classe_d = estado_q;
      case (estado_q)
         S_NORMAL: begin
            if (amostra < LB)       classe_d = S_BAIXO;
            else if (amostra >= LA) classe_d = S_ALTO;
         end
         S_BAIXO: begin
            if (amostra >= LA)       classe_d = S_ALTO;
            else if (amostra >= LBH) classe_d = S_NORMAL;
         end
         S_ALTO: begin
            if (amostra < LB)       classe_d = S_BAIXO;
            else if (amostra < LAH) classe_d = S_NORMAL;
         end
         default: classe_d = S_FALHA;
      endcase

      // A run continues only while the same candidate keeps appearing
      if (classe_d == candidato_q && conta_q != '0) conta_d = conta_q + 1'b1;
      else                                          conta_d = CNTW'(1);

      confirma_d = amostra_valida && !CFG_FALHA && (classe_d != estado_q) &&
                   (conta_d == CNTW'(CONFIRMA));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q     <= CFG_FALHA ? S_FALHA : S_NORMAL;
         candidato_q  <= S_NORMAL;
         mudou_q      <= 1'b0;
         conta_q      <= '0;
         cont_baixo_q <= '0;
         cont_alto_q  <= '0;
         min_q        <= '1;
         max_q        <= '0;
      end else begin
         mudou_q <= 1'b0;
         if (amostra_valida && !CFG_FALHA) begin
            if (classe_d == estado_q) begin
               conta_q     <= '0;
               candidato_q <= estado_q;
            end else if (confirma_d) begin
               estado_q    <= classe_d;
               mudou_q     <= 1'b1;
               conta_q     <= '0;
               candidato_q <= classe_d;
            end else begin
               conta_q     <= conta_d;
               candidato_q <= classe_d;
            end
         end

         if (limpa) begin
            cont_baixo_q <= '0;
            cont_alto_q  <= '0;
         end else if (confirma_d) begin
            if (classe_d == S_BAIXO && cont_baixo_q != '1) cont_baixo_q <= cont_baixo_q + 1'b1;
            if (classe_d == S_ALTO && cont_alto_q != '1)   cont_alto_q  <= cont_alto_q + 1'b1;
         end

         if (limpa) begin
            min_q <= '1;
            max_q <= '0;
         end else if (amostra_valida) begin
            if (pressao < min_q) min_q <= pressao;
            if (pressao > max_q) max_q <= pressao;
         end
      end
   end

   assign alerta       = estado_q;
   assign alerta_mudou = mudou_q;
   assign cont_baixo   = cont_baixo_q;
   assign cont_alto    = cont_alto_q;
   assign pressao_min  = min_q;
   assign pressao_max  = max_q;

endmodule

// File: tb/tb_monitoramento_pressao.sv
// Bench for monitoramento_pressao: five configurations share one stimulus stream;
// directed scenarios check constants, random traffic checks a behavioural model.
module tb_monitoramento_pressao;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] pressao = '0;
   logic       limpa = 1'b0;

   logic [1:0]  al_w [5];
   logic        mu_w [5];
   logic [15:0] cb_w [5];
   logic [15:0] ca_w [5];
   logic [7:0]  mn_w [5];
   logic [7:0]  mx_w [5];
   logic [1:0]  cb4, ca4;

   int total = 0;
   int bad   = 0;

   // Configurations: defaults, HIST=5, CONFIRMA=3, inverted limits (fault), CW=2
   int P_LB  [5] = '{50, 50, 50, 150, 50};
   int P_LA  [5] = '{150, 150, 150, 50, 150};
   int P_H   [5] = '{0, 5, 0, 0, 0};
   int P_CF  [5] = '{1, 1, 3, 1, 1};
   int P_CAP [5] = '{65535, 65535, 65535, 65535, 3};

   int m_al [5], m_cand [5], m_run [5], m_cb [5], m_ca [5], m_mn [5], m_mx [5];
   bit m_mu [5];

   always #5 clk = ~clk;

   monitoramento_pressao dut0 (
      .clk(clk), .rst(rst), .amostra_valida(valid), .pressao(pressao), .limpa(limpa),
      .alerta(al_w[0]), .alerta_mudou(mu_w[0]), .cont_baixo(cb_w[0]), .cont_alto(ca_w[0]),
      .pressao_min(mn_w[0]), .pressao_max(mx_w[0]));

   monitoramento_pressao #(.HIST(5)) dut1 (
      .clk(clk), .rst(rst), .amostra_valida(valid), .pressao(pressao), .limpa(limpa),
      .alerta(al_w[1]), .alerta_mudou(mu_w[1]), .cont_baixo(cb_w[1]), .cont_alto(ca_w[1]),
      .pressao_min(mn_w[1]), .pressao_max(mx_w[1]));

   monitoramento_pressao #(.CONFIRMA(3)) dut2 (
      .clk(clk), .rst(rst), .amostra_valida(valid), .pressao(pressao), .limpa(limpa),
      .alerta(al_w[2]), .alerta_mudou(mu_w[2]), .cont_baixo(cb_w[2]), .cont_alto(ca_w[2]),
      .pressao_min(mn_w[2]), .pressao_max(mx_w[2]));

   monitoramento_pressao #(.LIMITE_BAIXO(150), .LIMITE_ALTO(50)) dut3 (
      .clk(clk), .rst(rst), .amostra_valida(valid), .pressao(pressao), .limpa(limpa),
      .alerta(al_w[3]), .alerta_mudou(mu_w[3]), .cont_baixo(cb_w[3]), .cont_alto(ca_w[3]),
      .pressao_min(mn_w[3]), .pressao_max(mx_w[3]));

   monitoramento_pressao #(.CW(2)) dut4 (
      .clk(clk), .rst(rst), .amostra_valida(valid), .pressao(pressao), .limpa(limpa),
      .alerta(al_w[4]), .alerta_mudou(mu_w[4]), .cont_baixo(cb4), .cont_alto(ca4),
      .pressao_min(mn_w[4]), .pressao_max(mx_w[4]));

   assign cb_w[4] = {14'd0, cb4};
   assign ca_w[4] = {14'd0, ca4};

   function automatic bit falha(input int k);
      return (P_LB[k] >= P_LA[k]) || (P_H[k] >= P_LA[k] - P_LB[k]);
   endfunction

   // Class of sample p seen from current class s (0 normal, 1 low, 2 high)
   function automatic int classe(input int k, input int p, input int s);
      if (s == 1) return (p >= P_LA[k]) ? 2 : (p >= P_LB[k] + P_H[k]) ? 0 : 1;
      if (s == 2) return (p < P_LB[k]) ? 1 : (p < P_LA[k] - P_H[k]) ? 0 : 2;
      return (p < P_LB[k]) ? 1 : (p >= P_LA[k]) ? 2 : 0;
   endfunction

   task automatic modelo(input bit v, input int p, input bit l, input bit r);
      for (int k = 0; k < 5; k++) begin
         int c;
         bit entrou;
         entrou = 0;
         if (r) begin
            m_al[k] = falha(k) ? 3 : 0;
            m_cand[k] = -1; m_run[k] = 0; m_mu[k] = 0;
            m_cb[k] = 0; m_ca[k] = 0; m_mn[k] = 255; m_mx[k] = 0;
            continue;
         end
         m_mu[k] = 0;
         if (v && !falha(k)) begin
            c = classe(k, p, m_al[k]);
            if (c == m_al[k]) begin
               m_run[k] = 0; m_cand[k] = -1;
            end else begin
               m_run[k] = (c == m_cand[k]) ? m_run[k] + 1 : 1;
               m_cand[k] = c;
               if (m_run[k] >= P_CF[k]) begin
                  m_al[k] = c; m_mu[k] = 1; m_run[k] = 0; m_cand[k] = -1; entrou = 1;
               end
            end
         end
         if (l) begin
            m_cb[k] = 0; m_ca[k] = 0; m_mn[k] = 255; m_mx[k] = 0;
         end else begin
            if (entrou && m_al[k] == 1 && m_cb[k] < P_CAP[k]) m_cb[k]++;
            if (entrou && m_al[k] == 2 && m_ca[k] < P_CAP[k]) m_ca[k]++;
            if (v && p < m_mn[k]) m_mn[k] = p;
            if (v && p > m_mx[k]) m_mx[k] = p;
         end
      end
   endtask

   // One clock: inputs driven between edges, model advanced, outputs sampled 1 after the edge
   task automatic ciclo(input bit v, input int p, input bit l, input bit r);
      valid = v; pressao = p[7:0]; limpa = l; rst = r;
      @(posedge clk);
      modelo(v, p, l, r);
      #1;
   endtask

   task automatic amostra(input int p);
      ciclo(1'b1, p, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      ciclo(1'b0, 0, 1'b0, 1'b1);
      ciclo(1'b0, 0, 1'b0, 1'b0);
      total++;
      if (al_w[0] !== 2'b00 || mu_w[0] !== 1'b0 || cb_w[0] !== 16'd0 || ca_w[0] !== 16'd0 ||
          mn_w[0] !== 8'hFF || mx_w[0] !== 8'h00) begin
         bad++;
         $display("FAIL reset: alerta=%b mudou=%b cb=%0d ca=%0d min=%h max=%h, need 00 0 0 0 ff 00",
                  al_w[0], mu_w[0], cb_w[0], ca_w[0], mn_w[0], mx_w[0]);
      end
      total++;
      if (al_w[3] !== 2'b11) begin
         bad++;
         $display("FAIL reset_fault: alerta=%b need 11", al_w[3]);
      end
   endtask

   task automatic test_sequence;
      int seq [6] = '{30, 70, 160, 120, 45, 150};
      int exp [6] = '{1, 0, 2, 0, 1, 2};
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         amostra(seq[i]);
         total++;
         if (al_w[0] !== 2'(exp[i]) || mu_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL seq[%0d]: alerta=%b mudou=%b need %0d 1", i, al_w[0], mu_w[0], exp[i]);
         end
      end
      ciclo(1'b0, 0, 1'b0, 1'b0);
      total++;
      if (mu_w[0] !== 1'b0 || al_w[0] !== 2'b10) begin
         bad++;
         $display("FAIL seq_idle: alerta=%b mudou=%b need 10 0", al_w[0], mu_w[0]);
      end
   endtask

   task automatic test_boundaries;
      int seq [6] = '{49, 50, 149, 150, 0, 255};
      int exp [6] = '{1, 0, 0, 2, 1, 2};
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         amostra(seq[i]);
         total++;
         if (al_w[0] !== 2'(exp[i])) begin
            bad++;
            $display("FAIL limite p=%0d: alerta=%b need %0d", seq[i], al_w[0], exp[i]);
         end
      end
   endtask

   task automatic test_hysteresis;
      int seq [7] = '{200, 148, 145, 144, 10, 54, 55};
      int exp [7] = '{2, 2, 2, 0, 1, 1, 0};
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         amostra(seq[i]);
         total++;
         if (al_w[1] !== 2'(exp[i])) begin
            bad++;
            $display("FAIL hist p=%0d step %0d: alerta=%b need %0d", seq[i], i, al_w[1], exp[i]);
         end
      end
   endtask

   task automatic test_confirm;
      int seq [8] = '{160, 160, 70, 160, -1, 160, -1, 160};
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         if (seq[i] < 0) ciclo(1'b0, 0, 1'b0, 1'b0);
         else            amostra(seq[i]);
         total++;
         if (al_w[2] !== ((i == 7) ? 2'b10 : 2'b00) || mu_w[2] !== (i == 7)) begin
            bad++;
            $display("FAIL confirma step %0d: alerta=%b mudou=%b need %b %0d",
                     i, al_w[2], mu_w[2], (i == 7) ? 2'b10 : 2'b00, (i == 7));
         end
      end
   endtask

   task automatic test_stats;
      int seq [4] = '{30, 160, 45, 160};
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) amostra(seq[i]);
      total++;
      if (cb_w[0] !== 16'd2 || ca_w[0] !== 16'd2 || mn_w[0] !== 8'd30 || mx_w[0] !== 8'd160) begin
         bad++;
         $display("FAIL stats: cb=%0d ca=%0d min=%0d max=%0d need 2 2 30 160",
                  cb_w[0], ca_w[0], mn_w[0], mx_w[0]);
      end
      total++;
      if (al_w[3] !== 2'b11 || mn_w[3] !== 8'd30 || mx_w[3] !== 8'd160 || cb_w[3] !== 16'd0) begin
         bad++;
         $display("FAIL fault_stats: alerta=%b min=%0d max=%0d cb=%0d need 11 30 160 0",
                  al_w[3], mn_w[3], mx_w[3], cb_w[3]);
      end
      ciclo(1'b0, 0, 1'b1, 1'b0);
      total++;
      if (cb_w[0] !== 16'd0 || ca_w[0] !== 16'd0 || mn_w[0] !== 8'hFF || mx_w[0] !== 8'h00 ||
          al_w[0] !== 2'b10) begin
         bad++;
         $display("FAIL limpa: cb=%0d ca=%0d min=%h max=%h alerta=%b need 0 0 ff 00 10",
                  cb_w[0], ca_w[0], mn_w[0], mx_w[0], al_w[0]);
      end
   endtask

   task automatic test_saturation;
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         amostra(10);
         amostra(200);
      end
      total++;
      if (cb4 !== 2'd3 || ca4 !== 2'd3 || cb_w[0] !== 16'd5 || ca_w[0] !== 16'd5) begin
         bad++;
         $display("FAIL saturacao: cb4=%0d ca4=%0d cb=%0d ca=%0d need 3 3 5 5",
                  cb4, ca4, cb_w[0], ca_w[0]);
      end
   endtask

   task automatic test_reset_midrun;
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) amostra(160);
      amostra(10);
      amostra(10);
      total++;
      if (al_w[2] !== 2'b10) begin
         bad++;
         $display("FAIL midrun_pre: alerta=%b need 10", al_w[2]);
      end
      ciclo(1'b1, 10, 1'b0, 1'b1);
      total++;
      if (al_w[2] !== 2'b00 || mu_w[2] !== 1'b0 || cb_w[2] !== 16'd0 || ca_w[2] !== 16'd0 ||
          mn_w[2] !== 8'hFF || mx_w[2] !== 8'h00) begin
         bad++;
         $display("FAIL midrun_rst: alerta=%b mudou=%b cb=%0d ca=%0d min=%h max=%h need 00 0 0 0 ff 00",
                  al_w[2], mu_w[2], cb_w[2], ca_w[2], mn_w[2], mx_w[2]);
      end
      amostra(10);
      amostra(10);
      total++;
      if (al_w[2] !== 2'b00) begin
         bad++;
         $display("FAIL midrun_run_cleared: alerta=%b need 00", al_w[2]);
      end
   endtask

   task automatic test_random;
      ciclo(1'b0, 0, 1'b0, 1'b1);
      for (int n = 0; n < 1500; n++) begin
         int p;
         bit v, l, r;
         case ($urandom_range(0, 3))
            0:       p = $urandom_range(0, 255);
            1:       p = $urandom_range(44, 56);
            2:       p = $urandom_range(142, 156);
            default: p = $urandom_range(0, 1) ? $urandom_range(0, 20) : $urandom_range(200, 255);
         endcase
         v = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 40) == 0);
         r = ($urandom_range(0, 300) == 0);
         ciclo(v, p, l, r);
         for (int k = 0; k < 5; k++) begin
            total++;
            if (al_w[k] !== 2'(m_al[k]) || mu_w[k] !== m_mu[k] || cb_w[k] !== 16'(m_cb[k]) ||
                ca_w[k] !== 16'(m_ca[k]) || mn_w[k] !== 8'(m_mn[k]) || mx_w[k] !== 8'(m_mx[k])) begin
               bad++;
               $display("FAIL random n=%0d cfg=%0d: got al=%0d mu=%0d cb=%0d ca=%0d mn=%0d mx=%0d need %0d %0d %0d %0d %0d %0d",
                        n, k, al_w[k], mu_w[k], cb_w[k], ca_w[k], mn_w[k], mx_w[k],
                        m_al[k], m_mu[k], m_cb[k], m_ca[k], m_mn[k], m_mx[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_boundaries();
      test_hysteresis();
      test_confirm();
      test_stats();
      test_saturation();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
